// File: rtl/screen_pkg.sv
// Shared definitions for the text-mode screen memory controller:
// screen geometry, address/character widths and the controller state type.
package screen_pkg;

    localparam int COLS   = 40;
    localparam int ROWS   = 30;
    localparam int NCHARS = COLS * ROWS;
    localparam int ADDR_W = 11;
    localparam int CHAR_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } state_t;

endpackage

// File: rtl/screen_mem_ctrl.sv
// Arbiter for a single-port screen memory shared by the display refresh
// (highest priority, read-only), a handshaked character writer and a
// full-screen fill engine. The memory itself sits outside this block and
// returns read data combinationally for the address presented.
module screen_mem_ctrl #(
    parameter int NCHARS = screen_pkg::NCHARS,
    parameter int ADDR_W = screen_pkg::ADDR_W,
    parameter int CHAR_W = screen_pkg::CHAR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              disp_en,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [CHAR_W-1:0] disp_char,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [CHAR_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              clr_req,
    input  logic [CHAR_W-1:0] clr_data,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [CHAR_W-1:0] mem_wdata,
    input  logic [CHAR_W-1:0] mem_rdata
);
    import screen_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NCHARS - 1);
    localparam logic [ADDR_W:0]   DEPTH     = (ADDR_W + 1)'(NCHARS);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nxt;
    logic [CHAR_W-1:0] clr_code;
    logic              wr_in_range;

    // Writes outside the visible screen are acknowledged but never reach memory.
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH);

    assign busy = (state == CLEAR);

    // Controller state and fill counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Capture the fill code when a clear is accepted; it is pure data.
    always_ff @(posedge clk) begin
        if (state == IDLE && clr_req) begin
            clr_code <= clr_data;
        end
    end

    // Display character register: one cycle behind the address, zero when blanked.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_char <= '0;
        end else begin
            disp_char <= disp_en ? mem_rdata : '0;
        end
    end

    // Next-state and memory port control; the display steals the port in any state.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        wr_ack    = 1'b0;

        case (state)
            IDLE: begin
                // A clear beats a simultaneous write; the writer keeps its request up.
                if (clr_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end else if (wr_req) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (!disp_en) begin
                    mem_addr  = wr_addr;
                    mem_wdata = wr_data;
                    mem_we    = wr_in_range;
                    wr_ack    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            CLEAR: begin
                if (!disp_en) begin
                    mem_addr  = cnt;
                    mem_wdata = clr_code;
                    mem_we    = 1'b1;
                    // Stop on the last cell rather than wrapping the counter.
                    if (cnt == LAST_ADDR) begin
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (disp_en) begin
            mem_addr  = disp_addr;
            mem_we    = 1'b0;
            mem_wdata = '0;
        end

        // Reset must silence the memory port at once, not at the next edge.
        if (!reset_n) begin
            mem_addr  = '0;
            mem_we    = 1'b0;
            mem_wdata = '0;
            wr_ack    = 1'b0;
        end
    end

endmodule

// File: tb/tb_screen_mem_ctrl.sv
// Self-checking bench for screen_mem_ctrl with a behavioural screen memory.
module tb_screen_mem_ctrl;

    localparam int NCH = 1200;
    localparam int AW  = 11;
    localparam int CW  = 2;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b1;
    logic          disp_en   = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic          wr_req    = 1'b0;
    logic [AW-1:0] wr_addr   = '0;
    logic [CW-1:0] wr_data   = '0;
    logic          clr_req   = 1'b0;
    logic [CW-1:0] clr_data  = '0;
    logic [CW-1:0] disp_char;
    logic          wr_ack;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [CW-1:0] mem_wdata;
    logic [CW-1:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    int busy_count = 0;
    int ack_count = 0;
    int clr_exp_addr = 0;
    logic [CW-1:0] cur_clr = '0;
    logic [CW-1:0] exp_dc = '0;

    logic [CW-1:0] mem [0:2047] = '{default: '0};

    screen_mem_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .disp_en   (disp_en),
        .disp_addr (disp_addr),
        .disp_char (disp_char),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .clr_req   (clr_req),
        .clr_data  (clr_data),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // External single-port memory: combinational read, write on the clock edge.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected display character: whatever the screen held at the address the
    // display asked for one cycle earlier, or zero while the display is idle.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) exp_dc <= '0;
        else          exp_dc <= disp_en ? mem[disp_addr] : '0;
    end

    // Per-cycle compare against the port rules and the fill sequence.
    always @(negedge clk) begin
        chk("disp_char", int'(disp_char), int'(exp_dc));
        if (mem_we) wr_count++;
        if (busy)   busy_count++;
        if (wr_ack) ack_count++;
        if (reset_n) begin
            if (disp_en) begin
                chk("disp_owns_we", int'(mem_we), 0);
                chk("disp_owns_addr", int'(mem_addr), int'(disp_addr));
            end
            if (mem_we) begin
                chk("we_in_range", int'(int'(mem_addr) < NCH), 1);
                if (busy) begin
                    chk("clr_addr_seq", int'(mem_addr), clr_exp_addr);
                    chk("clr_wdata", int'(mem_wdata), int'(cur_clr));
                    clr_exp_addr++;
                end else begin
                    chk("wr_we_with_ack", int'(wr_ack), 1);
                end
            end
        end else begin
            chk("reset_we", int'(mem_we), 0);
        end
        if (!busy) clr_exp_addr = 0;
    end

    // Writer handshake: display owns the port for the first n_disp cycles.
    task automatic write_txn(input int addr, input int data, input int n_disp, input bit exp_we);
        int ack_at;
        int wc0;
        wc0    = wr_count;
        ack_at = -1;
        wr_addr = AW'(addr);
        wr_data = CW'(data);
        wr_req  = 1'b1;
        for (int cyc = 1; cyc <= n_disp + 4 && ack_at < 0; cyc++) begin
            disp_en   = (cyc <= n_disp);
            disp_addr = AW'(9);
            @(negedge clk);
            if (wr_ack) begin
                ack_at = cyc;
                chk("wr_we", int'(mem_we), int'(exp_we));
                if (exp_we) begin
                    chk("wr_mem_addr", int'(mem_addr), addr);
                    chk("wr_mem_wdata", int'(mem_wdata), data);
                end
            end
            tick();
        end
        wr_req  = 1'b0;
        disp_en = 1'b0;
        chk("wr_ack_cycle", ack_at, ((n_disp > 1) ? n_disp : 1) + 1);
        chk("wr_write_count", wr_count - wc0, exp_we ? 1 : 0);
        if (exp_we) chk("wr_mem_content", int'(mem[addr]), data);
    endtask

    // Full-screen fill with an optional display stall and an ignored re-request.
    task automatic clear_txn(input int data, input int stall_at, input int stall_len, input int reclr_at);
        int bc0;
        int wc0;
        int bad;
        int end_cyc;
        bc0 = busy_count;
        wc0 = wr_count;
        end_cyc = -1;
        cur_clr  = CW'(data);
        clr_data = CW'(data);
        clr_req  = 1'b1;
        @(negedge clk);
        chk("clr_busy_before", int'(busy), 0);
        tick();
        clr_req  = 1'b0;
        clr_data = CW'(data + 1);
        for (int cyc = 1; cyc < 1400; cyc++) begin
            disp_en   = (cyc >= stall_at && cyc < stall_at + stall_len);
            disp_addr = AW'(cyc);
            clr_req   = (cyc == reclr_at);
            if (clr_req) clr_data = CW'(data + 2);
            @(negedge clk);
            if (!busy) begin
                end_cyc = cyc;
                break;
            end
            tick();
        end
        clr_req = 1'b0;
        disp_en = 1'b0;
        tick();
        chk("clr_end_cycle", end_cyc, NCH + stall_len + 1);
        chk("clr_busy_cycles", busy_count - bc0, NCH + stall_len);
        chk("clr_write_count", wr_count - wc0, NCH);
        bad = 0;
        for (int i = 0; i < NCH; i++) if (int'(mem[i]) != data) bad++;
        chk("clr_mem_cells_wrong", bad, 0);
    endtask

    initial begin
        int wc0;
        int ack_at;
        int bad;

        // Reset with the display and a clear request active: port must stay quiet.
        #1;
        reset_n   = 1'b0;
        disp_en   = 1'b1;
        disp_addr = AW'(5);
        clr_req   = 1'b1;
        tick();
        tick();
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_mem_we", int'(mem_we), 0);
        chk("rst_mem_wdata", int'(mem_wdata), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_wr_ack", int'(wr_ack), 0);
        chk("rst_disp_char", int'(disp_char), 0);
        clr_req = 1'b0;
        disp_en = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_busy", int'(busy), 0);

        // Plain write puts code 2 at cell 5.
        write_txn(5, 2, 0, 1'b1);

        // Display read of cell 5: code 2 one cycle later, then 0 when blanked.
        disp_en   = 1'b1;
        disp_addr = AW'(5);
        @(negedge clk);
        chk("disp_mem_addr", int'(mem_addr), 5);
        chk("disp_mem_we", int'(mem_we), 0);
        tick();
        disp_en = 1'b0;
        @(negedge clk);
        chk("disp_char_lit", int'(disp_char), 2);
        tick();
        @(negedge clk);
        chk("disp_char_blank", int'(disp_char), 0);
        tick();

        // Write stalled by the display for four cycles, completes in cycle five.
        write_txn(100, 3, 4, 1'b1);
        chk("mem100_lit", int'(mem[100]), 3);

        // Off-screen write is acknowledged and dropped.
        write_txn(1200, 3, 0, 1'b0);

        // Full fill with code 1; a second request mid-fill is ignored.
        clear_txn(1, 0, 0, 300);
        chk("mem5_after_fill", int'(mem[5]), 1);

        // Simultaneous clear and write: the fill completes, then the write lands.
        wc0      = wr_count;
        ack_at   = -1;
        cur_clr  = CW'(3);
        clr_data = CW'(3);
        clr_req  = 1'b1;
        wr_addr  = AW'(7);
        wr_data  = CW'(1);
        wr_req   = 1'b1;
        for (int cyc = 0; cyc < 1400 && ack_at < 0; cyc++) begin
            if (cyc == 1) clr_req = 1'b0;
            @(negedge clk);
            if (wr_ack) begin
                ack_at = cyc;
                chk("sim_busy_at_ack", int'(busy), 0);
            end
            tick();
        end
        wr_req = 1'b0;
        chk("sim_ack_cycle", ack_at, NCH + 2);
        chk("sim_write_count", wr_count - wc0, NCH + 1);
        chk("sim_mem7", int'(mem[7]), 1);
        chk("sim_mem6", int'(mem[6]), 3);
        chk("sim_mem8", int'(mem[8]), 3);

        // Reset while the fill counter sits at 600.
        wc0      = wr_count;
        cur_clr  = CW'(2);
        clr_data = CW'(2);
        clr_req  = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (600) tick();
        chk("rstclr_pre_writes", wr_count - wc0, 600);
        chk("rstclr_pre_busy", int'(busy), 1);
        reset_n = 1'b0;
        #1;
        chk("rstclr_busy", int'(busy), 0);
        chk("rstclr_we", int'(mem_we), 0);
        chk("rstclr_addr", int'(mem_addr), 0);
        wc0 = wr_count;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (5) tick();
        chk("rstclr_no_writes", wr_count - wc0, 0);
        chk("rstclr_busy_after", int'(busy), 0);
        bad = 0;
        for (int i = 0; i < 600; i++) if (mem[i] != 2'd2) bad++;
        chk("rstclr_low_cells_wrong", bad, 0);
        bad = 0;
        for (int i = 600; i < NCH; i++) if (mem[i] != 2'd3) bad++;
        chk("rstclr_high_cells_wrong", bad, 0);

        // Fill with a ten-cycle display stall: counter holds, fill takes longer.
        clear_txn(0, 10, 10, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
